// File: rtl/nibble_addsub_pkg.sv
// rtl/nibble_addsub_pkg.sv - shared FSM state and op encodings for the nibble-serial add/subtract unit
package nibble_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/four_bit_rca.sv
// rtl/four_bit_rca.sv - 4-bit ripple-carry adder used as the shared nibble datapath
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder bit slices
    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = Cin;
        for (int k = 0; k < 4; k++) begin
            S[k]     = A[k] ^ B[k] ^ c[k];
            c[k + 1] = (A[k] & B[k]) | (c[k] & (A[k] ^ B[k]));
        end
        Cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - nibble-serial add/subtract/negate, overflow flag enabled by NIBBLE_ADDSUB_OVF_EN
module nibble_serial_addsub
    import nibble_addsub_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         done_valid,
    input  logic         done_ready
);

    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  res_q;
    logic          carry;
    logic          accept;
    logic          last_nibble;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_cout;

    assign accept      = (state == IDLE) && start_valid;
    assign last_nibble = (idx == LAST_IDX);
    assign nib_a       = opa[4*idx +: 4];
    assign nib_b       = opb[4*idx +: 4];

    // The carry register is preloaded with the op's carry-in at acceptance,
    // so it feeds nibble 0 directly and then chains nibble to nibble.
    four_bit_rca u_rca (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry),
        .S    (nib_s),
        .Cout (nib_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE always passes through IDLE before a new RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            DONE:    if (done_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on acceptance and one nibble of work per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            opa   <= '0;
            opb   <= '0;
            res_q <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            idx <= '0;
            case (op)
                OP_SUB: begin
                    opa   <= a;
                    opb   <= ~b;
                    carry <= 1'b1;
                end
                OP_NEG: begin
                    opa   <= '0;
                    opb   <= ~a;
                    carry <= 1'b1;
                end
                default: begin
                    opa   <= a;
                    opb   <= b;
                    carry <= 1'b0;
                end
            endcase
        end else if (state == RUN) begin
            res_q[4*idx +: 4] <= nib_s;
            carry             <= nib_cout;
            idx               <= last_nibble ? '0 : idx + 1'b1;
        end
    end

`ifdef NIBBLE_ADDSUB_OVF_EN
    logic ovf_q;

    // Overflow: operands agree in sign but the final sum's sign differs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && last_nibble) begin
            ovf_q <= (opa[W-1] == opb[W-1]) && (nib_s[3] != opa[W-1]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign result      = res_q;
    assign cout        = carry;

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand; legal range 2..8.
REQ-002 SHALL have parameter W, default 4*NIBBLES, giving the operand width; W is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start_valid  input  1  request valid.
REQ-006 start_ready  output  1  block idle, request acceptable.
REQ-007 op  input  2  operation: 00 add A+B, 01 subtract A-B, 10 negate -A, 11 reserved (executes as add).
REQ-008 a  input  W  operand A, sampled on acceptance.
REQ-009 b  input  W  operand B, sampled on acceptance; ignored for negate.
REQ-010 result  output  W  sum or difference, valid while done_valid=1.
REQ-011 cout  output  1  carry out of the MSB nibble, valid while done_valid=1.
REQ-012 ovf  output  1  signed two's-complement overflow, valid while done_valid=1.
REQ-013 done_valid  output  1  result available.
REQ-014 done_ready  input  1  consumer accepts the result.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 start_ready SHALL be 1 only in IDLE; acceptance is start_valid=1 and start_ready=1 on a rising edge.
REQ-017 On acceptance, SHALL latch the effective operands and carry-in, then go to RUN with nibble index 0. Mapping: add A'=a, B'=b, cin=0; subtract A'=a, B'=~b, cin=1; negate A'=0, B'=~a, cin=1.
REQ-018 Each RUN cycle SHALL process exactly one nibble, LSB first, through a single 4-bit ripple-carry adder. Its carry-in is cin for nibble 0 and otherwise the registered carry-out of the previous nibble.
REQ-019 Each RUN cycle SHALL write the nibble sum into result[4*i+3:4*i] and register the nibble carry-out.
REQ-020 After nibble NIBBLES-1, SHALL enter DONE. done_valid therefore rises exactly NIBBLES rising edges after the acceptance edge.
REQ-021 In DONE, result, cout and ovf SHALL be held stable until done_valid=1 and done_ready=1 on a rising edge; the FSM then returns to IDLE.
REQ-022 The FSM SHALL NOT pass from DONE directly to RUN. The minimum spacing between acceptances is NIBBLES+2 cycles when done_ready is held at 1.
REQ-023 ovf SHALL be 1 exactly when A'[W-1]==B'[W-1] and result[W-1]!=A'[W-1].
REQ-024 Changes on a, b and op outside the acceptance edge SHALL have no effect.
REQ-025 start_valid while busy SHALL be ignored and not queued; start_ready=0 tells the requester to hold the request.
REQ-026 The nibble index SHALL be exactly ceil(log2(NIBBLES)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-027 While rst_n=0, SHALL force: state IDLE, index 0, carry 0, result 0, cout 0, ovf 0, done_valid 0; start_ready=1 once state is IDLE.
REQ-028 A reset asserted during RUN or DONE SHALL abandon the operation with no partial result retained.

Configuration
REQ-029 Macro NIBBLE_ADDSUB_OVF_EN controls the overflow flag.
REQ-030 With NIBBLE_ADDSUB_OVF_EN defined, ovf SHALL be computed per REQ-023.
REQ-031 Without NIBBLE_ADDSUB_OVF_EN, the ovf port SHALL remain and be tied to 0, with no overflow logic or sign-bit storage synthesized.

Structure
REQ-032 Package nibble_addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the op encoding constants OP_ADD, OP_SUB, OP_NEG, OP_RSV.
REQ-033 SHALL instantiate exactly one existing four_bit_rca (ports A, B, Cin, S, Cout) as the shared nibble datapath.
REQ-034 Nibble selection muxes, carry register and FSM SHALL be local to nibble_serial_addsub.

Verification
REQ-035 Add, NIBBLES=4: a=16'h00FF, b=16'h0001 -> result 16'h0100, cout 0, ovf 0; done_valid rises 4 edges after acceptance.
REQ-036 Subtract: a=16'h0005, b=16'h0007 -> result 16'hFFFE, cout 0, ovf 0. Subtract a=16'h8000, b=16'h0001 -> result 16'h7FFF, cout 1, ovf 1.
REQ-037 Negate: a=16'h0001 -> result 16'hFFFF. Negate a=16'h8000 -> result 16'h8000, ovf 1. Negate a=16'h0000 -> result 16'h0000, cout 1.
REQ-038 Add a=16'hFFFF, b=16'hFFFF -> result 16'hFFFE, cout 1, ovf 0.
REQ-039 Backpressure: hold done_ready=0 for 5 cycles in DONE -> outputs stable, start_ready=0, start_valid pulses ignored. Releasing done_ready -> IDLE next edge.
REQ-040 Drive rst_n low at RUN index 2 -> all outputs 0 immediately, start_ready=1. The next request completes correctly. With the macro undefined, ovf stays 0 for the REQ-036 overflow case.
